// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: multiplier FSM encoding and iteration bound.
package alsu_pkg;

    // Multiplier control states; encoding 2'd3 is illegal and recovers to idle.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Counter value on the final shift-add iteration (four iterations total).
    localparam logic [1:0] ITER_LAST = 2'd3;

endpackage

// File: rtl/seq_multiplier_4bit_if.sv
// Handshake and operand/result bundle between ALSU control and the multiplier.
interface seq_multiplier_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sel;
    logic [WIDTH-1:0] Out;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Sel,
        input  Out, busy, done
    );

    modport slave (
        input  start, A, B, Sel,
        output Out, busy, done
    );
endinterface

// File: rtl/Mux_2_to_1_four_bits.sv
// Two-way selector for 4-bit values.
module Mux_2_to_1_four_bits (
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       sel,
    output logic [3:0] y
);
    // sel = 1 picks in1, otherwise in0.
    always_comb begin
        y = sel ? in1 : in0;
    end
endmodule

// File: rtl/four_bit_adder.sv
// Unsigned 4-bit adder with carry-out.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);
    // Five-bit sum split into carry and nibble.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b};
    end
endmodule

// File: rtl/seq_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-add multiplier. The 8-bit product is held
// between operations and read out one nibble at a time through Sel/Out.
module seq_multiplier_4bit
    import alsu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_multiplier_4bit_if.slave bus
);
    mul_state_t         state;
    logic [1:0]         cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic [2*WIDTH-1:0] prod;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH-1:0]   add_sum;
    logic               add_c;
    logic [WIDTH-1:0]   hi_sel;
    logic               c_sel;
    logic [WIDTH-1:0]   next_hi;
    logic [WIDTH-1:0]   next_lo;
    logic               accept;
    logic [WIDTH-1:0]   out_nib;

    four_bit_adder u_add (
        .a    (p_hi),
        .b    (mcand),
        .sum  (add_sum),
        .cout (add_c)
    );

    // One shift-add step: conditionally add the multiplicand, then shift {c, P_hi, P_lo} right.
    always_comb begin
        hi_sel  = p_lo[0] ? add_sum : p_hi;
        c_sel   = p_lo[0] & add_c;
        next_hi = {c_sel, hi_sel[WIDTH-1:1]};
        next_lo = {hi_sel[0], p_lo[WIDTH-1:1]};
        accept  = bus.start && ((state == MUL_IDLE) || (state == MUL_DONE));
    end

    // Control FSM, iteration counter, accumulator and product register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MUL_IDLE;
            cnt    <= 2'd0;
            mcand  <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            prod   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (accept) begin
            // New operation from IDLE or straight out of DONE.
            state  <= MUL_RUN;
            cnt    <= 2'd0;
            mcand  <= bus.A;
            p_hi   <= '0;
            p_lo   <= bus.B;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                MUL_RUN: begin
                    p_hi <= next_hi;
                    p_lo <= next_lo;
                    cnt  <= cnt + 2'd1;
                    if (cnt == ITER_LAST) begin
                        prod   <= {next_hi, next_lo};
                        state  <= MUL_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    state  <= MUL_IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= MUL_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    Mux_2_to_1_four_bits u_mux (
        .in0 (prod[WIDTH-1:0]),
        .in1 (prod[2*WIDTH-1:WIDTH]),
        .sel (bus.Sel),
        .y   (out_nib)
    );

    assign bus.Out  = out_nib;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Directed bench for the sequential 4x4 multiplier.
module tb_seq_multiplier_4bit;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    seq_multiplier_4bit_if #(.WIDTH(4)) mif ();

    seq_multiplier_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Read the full product through the nibble port.
    task automatic read_prod(output logic [7:0] p);
        mif.Sel = 1'b0;
        #1;
        p[3:0] = mif.Out;
        mif.Sel = 1'b1;
        #1;
        p[7:4] = mif.Out;
    endtask

    // Pulse start with a/b, observe 8 cycles; optionally re-pulse start with other operands.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int repulse_at,
                          output int busy_cnt, output int done_cnt, output int done_idx,
                          output logic [7:0] p);
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        p        = 8'hxx;
        mif.A     = a;
        mif.B     = b;
        mif.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            mif.start = 1'b0;
            if (i == repulse_at) begin
                mif.A     = 4'd1;
                mif.B     = 4'd1;
                mif.start = 1'b1;
            end
            if (mif.busy) busy_cnt++;
            if (mif.done) begin
                done_cnt++;
                done_idx = i;
                read_prod(p);
            end
        end
    endtask

    logic [7:0] p;
    int         bc, dc, di, late_done;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        mif.start = 1'b0;
        mif.A     = 4'd0;
        mif.B     = 4'd0;
        mif.Sel   = 1'b0;
        step(2);

        // Reset state
        check("rst_busy", {7'd0, mif.busy}, 8'd0);
        check("rst_done", {7'd0, mif.done}, 8'd0);
        read_prod(p);
        check("rst_prod", p, 8'h00);
        rst_n = 1'b1;
        step(1);

        // 15 x 15: done exactly 4 cycles after the accepting edge
        mif.A = 4'd15; mif.B = 4'd15; mif.start = 1'b1;
        step(1);
        mif.start = 1'b0;
        check("ff_busy_n0", {7'd0, mif.busy}, 8'd1);
        check("ff_done_n0", {7'd0, mif.done}, 8'd0);
        step(3);
        check("ff_busy_n3", {7'd0, mif.busy}, 8'd1);
        check("ff_done_n3", {7'd0, mif.done}, 8'd0);
        step(1);
        check("ff_done_n4", {7'd0, mif.done}, 8'd1);
        check("ff_busy_n4", {7'd0, mif.busy}, 8'd0);
        mif.Sel = 1'b0; #1;
        check("ff_lo", {4'd0, mif.Out}, 8'h01);
        mif.Sel = 1'b1; #1;
        check("ff_hi", {4'd0, mif.Out}, 8'h0E);

        // 7 x 3 launched straight from DONE; Out holds 0xE during RUN
        mif.A = 4'd7; mif.B = 4'd3; mif.start = 1'b1;
        step(1);
        mif.start = 1'b0;
        check("73_done_drop", {7'd0, mif.done}, 8'd0);
        check("73_busy", {7'd0, mif.busy}, 8'd1);
        check("73_hold_n0", {4'd0, mif.Out}, 8'h0E);
        step(3);
        check("73_hold_n3", {4'd0, mif.Out}, 8'h0E);
        step(1);
        check("73_done", {7'd0, mif.done}, 8'd1);
        mif.Sel = 1'b0; #1;
        check("73_lo", {4'd0, mif.Out}, 8'h05);
        mif.Sel = 1'b1; #1;
        check("73_hi", {4'd0, mif.Out}, 8'h01);
        step(2);

        // Zero operands
        run_op(4'd0, 4'd9, -1, bc, dc, di, p);
        check("09_busy_cycles", bc[7:0], 8'd4);
        check("09_done_count", dc[7:0], 8'd1);
        check("09_done_idx", di[7:0], 8'd4);
        check("09_prod", p, 8'h00);
        run_op(4'd9, 4'd0, -1, bc, dc, di, p);
        check("90_busy_cycles", bc[7:0], 8'd4);
        check("90_done_count", dc[7:0], 8'd1);
        check("90_prod", p, 8'h00);

        // Start re-pulsed mid-RUN is ignored
        run_op(4'd5, 4'd5, 1, bc, dc, di, p);
        check("55_done_count", dc[7:0], 8'd1);
        check("55_done_idx", di[7:0], 8'd4);
        check("55_prod", p, 8'h19);

        // Start held high: a new 3 x 4 result every 5 cycles
        mif.A = 4'd3; mif.B = 4'd4; mif.Sel = 1'b0; mif.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("hold_done_%0d", i), {7'd0, mif.done},
                  ((i == 4) || (i == 9)) ? 8'd1 : 8'd0);
            check($sformatf("hold_busy_%0d", i), {7'd0, mif.busy},
                  ((i == 4) || (i == 9)) ? 8'd0 : 8'd1);
            check($sformatf("hold_out_%0d", i), {4'd0, mif.Out},
                  (i < 4) ? 8'h09 : 8'h0C);
        end
        mif.start = 1'b0;
        step(6);
        read_prod(p);
        check("hold_prod", p, 8'h0C);

        // Reset mid-RUN abandons the operation and clears the product
        mif.A = 4'd15; mif.B = 4'd15; mif.start = 1'b1;
        step(1);
        mif.start = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("mrst_busy", {7'd0, mif.busy}, 8'd0);
        check("mrst_done", {7'd0, mif.done}, 8'd0);
        read_prod(p);
        check("mrst_prod", p, 8'h00);
        late_done = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (mif.done || mif.busy) late_done++;
        end
        check("mrst_no_done", late_done[7:0], 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
